// File: rtl/store_monitor.sv
// Pass/fail monitor for the core's data-memory write port, with a store-log FIFO.
// Optional macro STORE_MON_BYTE_EN adds byte-lane strobes (MemStrb, log_strb).
module store_monitor #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned PASS_ADDR      = 100,
    parameter int unsigned PASS_DATA      = 25,
    parameter int unsigned SCRATCH_LO     = 96,
    parameter int unsigned SCRATCH_HI     = 96,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned LOG_DEPTH      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [XLEN-1:0]   ALUResult,
    input  logic [XLEN-1:0]   WriteData,
`ifdef STORE_MON_BYTE_EN
    input  logic [XLEN/8-1:0] MemStrb,
    output logic [XLEN/8-1:0] log_strb,
`endif
    input  logic              log_pop,
    output logic              log_valid,
    output logic [XLEN-1:0]   log_addr,
    output logic [XLEN-1:0]   log_data,
    output logic              log_overflow,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [15:0]       store_count,
    output logic [31:0]       cycle_count
);

    localparam int unsigned     AW         = $clog2(LOG_DEPTH);
    localparam logic [XLEN-1:0] P_ADDR     = XLEN'(PASS_ADDR);
    localparam logic [XLEN-1:0] P_DATA     = XLEN'(PASS_DATA);
    localparam logic [XLEN-1:0] S_LO       = XLEN'(SCRATCH_LO);
    localparam logic [XLEN-1:0] S_HI       = XLEN'(SCRATCH_HI);
    localparam logic [31:0]     TOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TOUT
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [XLEN-1:0] addr_mem [LOG_DEPTH];
    logic [XLEN-1:0] data_mem [LOG_DEPTH];

    logic store_valid;
    logic data_match;
    logic accept;
    logic in_scratch;
    logic timeout_hit;
    logic full;
    logic do_push;
    logic do_pop;

`ifdef STORE_MON_BYTE_EN
    logic [XLEN/8-1:0] strb_mem [LOG_DEPTH];
    logic [XLEN-1:0]   strb_mask;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        strb_mask = '0;
        for (int i = 0; i < XLEN / 8; i++) begin
            strb_mask[i*8 +: 8] = {8{MemStrb[i]}};
        end
    end

    // An all-zero strobe is not a store at all.
    assign store_valid = MemWrite && (MemStrb != '0);
    assign data_match  = (WriteData & strb_mask) == (P_DATA & strb_mask);
`else
    assign store_valid = MemWrite;
    assign data_match  = (WriteData == P_DATA);
`endif

    assign accept     = (state == ST_RUN) && store_valid;
    assign in_scratch = (ALUResult >= S_LO) && (ALUResult <= S_HI);
    // >= rather than == so a scratch store landing on the limit edge only defers the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count >= TOUT_LAST);

    assign full    = (count == FULL_COUNT);
    assign do_pop  = log_pop && log_valid;
    assign do_push = accept && (!full || do_pop);

    assign log_valid = (count != '0);
    assign log_addr  = log_valid ? addr_mem[rd_ptr] : '0;
    assign log_data  = log_valid ? data_mem[rd_ptr] : '0;
    assign done      = pass | fail | timeout;

    // NOTE: log storage has no reset; pointers and occupancy alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= ALUResult;
            data_mem[wr_ptr] <= WriteData;
`ifdef STORE_MON_BYTE_EN
            strb_mem[wr_ptr] <= MemStrb;
`endif
        end
    end

`ifdef STORE_MON_BYTE_EN
    assign log_strb = log_valid ? strb_mem[rd_ptr] : '0;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            store_count  <= '0;
            cycle_count  <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (state == ST_RUN) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if (accept) begin
                    if (store_count != '1) begin
                        store_count <= store_count + 16'd1;
                    end
                    if (ALUResult == P_ADDR) begin
                        if (data_match) begin
                            state <= ST_PASS;
                            pass  <= 1'b1;
                        end else begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end
                    end else if (!in_scratch) begin
                        state <= ST_FAIL;
                        fail  <= 1'b1;
                    end
                end else if (timeout_hit) begin
                    state   <= ST_TOUT;
                    timeout <= 1'b1;
                end
            end

            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (accept && full && !do_pop) begin
                log_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: a table of single-store verdicts plus hand-written
// sequences for pass, terminal-state, timeout, log overflow and mid-test reset.
module tb_store_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        log_pop;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] store_count;
    logic [31:0] cycle_count;
`ifdef STORE_MON_BYTE_EN
    logic [3:0]  MemStrb = 4'hF;
    logic [3:0]  log_strb;
`endif

    int errors = 0;
    int checks = 0;

    store_monitor #(
        .LOG_DEPTH      (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
`ifdef STORE_MON_BYTE_EN
        .MemStrb      (MemStrb),
        .log_strb     (log_strb),
`endif
        .log_pop      (log_pop),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .store_count  (store_count),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_pass;
        logic        exp_fail;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic do_reset(input int n);
        reset    = 1'b1;
        MemWrite = 1'b0;
        log_pop  = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic pop);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        log_pop   = pop;
        @(negedge clk);
        MemWrite = 1'b0;
        log_pop  = 1'b0;
    endtask

    task automatic pop_one();
        log_pop = 1'b1;
        @(negedge clk);
        log_pop = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " done"},        64'(done), 64'd0);
        check({tag, " pass"},        64'(pass), 64'd0);
        check({tag, " fail"},        64'(fail), 64'd0);
        check({tag, " timeout"},     64'(timeout), 64'd0);
        check({tag, " store_count"}, 64'(store_count), 64'd0);
        check({tag, " cycle_count"}, 64'(cycle_count), 64'd0);
        check({tag, " log_valid"},   64'(log_valid), 64'd0);
        check({tag, " overflow"},    64'(log_overflow), 64'd0);
        check({tag, " log_addr"},    64'(log_addr), 64'd0);
        check({tag, " log_data"},    64'(log_data), 64'd0);
    endtask

    task automatic pass_sequence(input string tag);
        store(32'd96, 32'd7, 1'b0);
        check({tag, " after scratch done"}, 64'(done), 64'd0);
        store(32'd100, 32'd25, 1'b0);
        check({tag, " pass"},        64'(pass), 64'd1);
        check({tag, " fail"},        64'(fail), 64'd0);
        check({tag, " timeout"},     64'(timeout), 64'd0);
        check({tag, " done"},        64'(done), 64'd1);
        check({tag, " store_count"}, 64'(store_count), 64'd2);
        check({tag, " head0 addr"},  64'(log_addr), 64'd96);
        check({tag, " head0 data"},  64'(log_data), 64'd7);
        pop_one();
        check({tag, " head1 addr"},  64'(log_addr), 64'd100);
        check({tag, " head1 data"},  64'(log_data), 64'd25);
        pop_one();
        check({tag, " log empty"},   64'(log_valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{"pass exact",     32'd100, 32'd25, 1'b1, 1'b0};
        vecs[1] = '{"pass bad data",  32'd100, 32'd26, 1'b0, 1'b1};
        vecs[2] = '{"pass data zero", 32'd100, 32'd0,  1'b0, 1'b1};
        vecs[3] = '{"far addr",       32'd200, 32'd25, 1'b0, 1'b1};
        vecs[4] = '{"scratch",        32'd96,  32'd5,  1'b0, 1'b0};
        vecs[5] = '{"below scratch",  32'd95,  32'd0,  1'b0, 1'b1};
        vecs[6] = '{"above scratch",  32'd97,  32'd0,  1'b0, 1'b1};
        vecs[7] = '{"pass addr + 1",  32'd101, 32'd25, 1'b0, 1'b1};

        ALUResult = '0;
        WriteData = '0;
        @(negedge clk);

        // Reset state and the basic pass run.
        do_reset(2);
        check_cleared("reset");
        pass_sequence("run1");
        check("run1 cycle_count frozen", 64'(cycle_count), 64'd2);
        pop_one();
        check("pop empty ignored", 64'(log_valid), 64'd0);

        // Single-store verdict table.
        foreach (vecs[i]) begin
            do_reset(1);
            store(vecs[i].addr, vecs[i].data, 1'b0);
            check({vecs[i].name, " pass"},        64'(pass), 64'(vecs[i].exp_pass));
            check({vecs[i].name, " fail"},        64'(fail), 64'(vecs[i].exp_fail));
            check({vecs[i].name, " done"},        64'(done), 64'(vecs[i].exp_pass | vecs[i].exp_fail));
            check({vecs[i].name, " store_count"}, 64'(store_count), 64'd1);
            check({vecs[i].name, " log addr"},    64'(log_addr), 64'(vecs[i].addr));
            check({vecs[i].name, " log data"},    64'(log_data), 64'(vecs[i].data));
        end

        // Stores after a verdict are ignored.
        do_reset(1);
        store(32'd200, 32'd1, 1'b0);
        store(32'd100, 32'd25, 1'b0);
        check("term fail",        64'(fail), 64'd1);
        check("term pass",        64'(pass), 64'd0);
        check("term store_count", 64'(store_count), 64'd1);
        pop_one();
        check("term not logged",  64'(log_valid), 64'd0);

        // Timeout: no stores, verdict after the 50th cycle, counter frozen at 50.
        do_reset(1);
        repeat (49) @(negedge clk);
        check("tout early",       64'(timeout), 64'd0);
        check("tout cc 49",       64'(cycle_count), 64'd49);
        @(negedge clk);
        check("tout flag",        64'(timeout), 64'd1);
        check("tout done",        64'(done), 64'd1);
        check("tout cc 50",       64'(cycle_count), 64'd50);
        repeat (10) @(negedge clk);
        check("tout cc frozen",   64'(cycle_count), 64'd50);
        check("tout pass",        64'(pass), 64'd0);

        // A deciding store on the timeout edge wins.
        do_reset(1);
        repeat (49) @(negedge clk);
        store(32'd100, 32'd25, 1'b0);
        check("race pass",        64'(pass), 64'd1);
        check("race timeout",     64'(timeout), 64'd0);
        repeat (5) @(negedge clk);
        check("race timeout late", 64'(timeout), 64'd0);

        // Log overflow with depth 4.
        do_reset(1);
        for (int k = 1; k <= 4; k++) store(32'd96, 32'(k), 1'b0);
        check("ovf not yet",      64'(log_overflow), 64'd0);
        store(32'd96, 32'd5, 1'b0);
        check("ovf flag",         64'(log_overflow), 64'd1);
        check("ovf store_count",  64'(store_count), 64'd5);
        check("ovf head",         64'(log_data), 64'd1);
        store(32'd96, 32'd6, 1'b1);
        check("ovf push+pop sc",  64'(store_count), 64'd6);
        check("ovf sticky",       64'(log_overflow), 64'd1);
        begin
            logic [31:0] exp_q [4];
            exp_q[0] = 32'd2;
            exp_q[1] = 32'd3;
            exp_q[2] = 32'd4;
            exp_q[3] = 32'd6;
            foreach (exp_q[j]) begin
                check($sformatf("ovf entry %0d valid", j), 64'(log_valid), 64'd1);
                check($sformatf("ovf entry %0d data", j),  64'(log_data), 64'(exp_q[j]));
                pop_one();
            end
        end
        check("ovf drained",      64'(log_valid), 64'd0);

        // Mid-test reset after a pass clears everything; a rerun passes again.
        do_reset(1);
        store(32'd96, 32'd9, 1'b0);
        store(32'd100, 32'd25, 1'b0);
        check("pre-reset pass",   64'(pass), 64'd1);
        do_reset(1);
        check_cleared("midreset");
        pass_sequence("run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
